// File: rtl/minrv32_bus_pkg.sv
// Shared types for the minrv32 native memory bus arbiter: FSM states, grant ids
// and the registered request that is driven onto the memory bus.
package minrv32_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_STRB_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_e;

    typedef enum logic {
        FETCH,
        DATA
    } grant_e;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] wstrb;
        logic                  instr;
    } req_t;

endpackage

// File: rtl/minrv32_rr_pick.sv
// Two-requester round-robin picker: on contention the port that did not win
// last time is chosen.
module minrv32_rr_pick
    import minrv32_bus_pkg::*;
(
    input  logic   fetch_req_i,
    input  logic   data_req_i,
    input  grant_e last_grant_i,
    output logic   grant_valid_o,
    output grant_e winner_o
);

    always_comb begin
        grant_valid_o = fetch_req_i | data_req_i;
        winner_o      = FETCH;
        if (fetch_req_i && data_req_i) begin
            winner_o = (last_grant_i == FETCH) ? DATA : FETCH;
        end else if (data_req_i) begin
            winner_o = DATA;
        end
    end

endmodule

// File: rtl/minrv32_mem_arbiter.sv
// Shares the single minrv32 memory bus between fetch and load/store ports with
// round-robin arbitration, registered request fields and a wait watchdog.
module minrv32_mem_arbiter
    import minrv32_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_valid,
    output logic                m_instr,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    grant_e             last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;

    logic               grant_valid;
    grant_e             winner;
    logic               timeout;
    logic               done;
    logic [DATA_W-1:0]  rdata;

    minrv32_rr_pick u_pick (
        .fetch_req_i   (i_valid),
        .data_req_i    (d_valid),
        .last_grant_i  (last_q),
        .grant_valid_o (grant_valid),
        .winner_o      (winner)
    );

    // A real completion on the timeout cycle wins over the forced error.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT));
    assign done    = m_ready | timeout;
    assign rdata   = m_ready ? m_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= DATA;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        i_ready = 1'b0;
        i_err   = 1'b0;
        i_rdata = '0;
        d_ready = 1'b0;
        d_err   = 1'b0;
        d_rdata = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    cnt_d  = '0;
                    last_d = winner;
                    if (winner == FETCH) begin
                        req_d.addr  = BUS_ADDR_W'(i_addr);
                        req_d.wdata = '0;
                        req_d.wstrb = '0;
                        req_d.instr = 1'b1;
                        state_d     = GNT_I;
                    end else begin
                        req_d.addr  = BUS_ADDR_W'(d_addr);
                        req_d.wdata = BUS_DATA_W'(d_wdata);
                        req_d.wstrb = BUS_STRB_W'(d_wstrb);
                        req_d.instr = 1'b0;
                        state_d     = GNT_D;
                    end
                end
            end
            GNT_I: begin
                if (done) begin
                    i_ready = 1'b1;
                    i_err   = ~m_ready;
                    i_rdata = rdata;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GNT_D: begin
                if (done) begin
                    d_ready = 1'b1;
                    d_err   = ~m_ready;
                    d_rdata = rdata;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign m_valid = busy;
    assign m_instr = req_q.instr;
    assign m_addr  = ADDR_W'(req_q.addr);
    assign m_wdata = DATA_W'(req_q.wdata);
    assign m_wstrb = (DATA_W/8)'(req_q.wstrb);

endmodule
